// File: rtl/ex_mem_reg_pkg.sv
// ex_mem_reg_pkg
//   Shared definitions for the EX/MEM pipeline stage: condition-op encodings,
//   trap FSM states and a small decode helper.
package ex_mem_reg_pkg;

    typedef enum logic [2:0] {
        COND_NONE = 3'd0,
        COND_EQZ  = 3'd1,
        COND_NEZ  = 3'd2,
        COND_LTZ  = 3'd3,
        COND_GEZ  = 3'd4,
        COND_SEQ  = 3'd5,
        COND_SLT  = 3'd6,
        COND_SCO  = 3'd7
    } cond_op_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } state_e;

    // Conditional branches (EQZ..GEZ) never write back a register.
    function automatic logic is_branch_op(input logic [2:0] op);
        return (op >= COND_EQZ) && (op <= COND_GEZ);
    endfunction

endpackage

// File: rtl/ex_mem_reg_if.sv
// ex_mem_reg_if
//   Bundles the EX-side instruction inputs, the MEM-side registered outputs
//   and the trap handshake of the EX/MEM stage.
//   master : the surrounding pipeline/control (drives ex_*, mem_stall, flush, err_ack)
//   slave  : the ex_mem_reg stage itself
interface ex_mem_reg_if #(
    parameter int W  = 16,
    parameter int RW = 3
);
    // EX side
    logic          ex_valid;
    logic          ex_ready;
    logic [W-1:0]  ex_alu_out;
    logic          ex_ofl;
    logic          ex_z;
    logic          ex_sign;
    logic [2:0]    ex_cond_op;
    logic          ex_trap_ofl;
    logic [W-1:0]  ex_pc_plus2;
    logic [W-1:0]  ex_br_target;
    logic [RW-1:0] ex_wr_reg;
    logic          ex_wr_en;
    logic          ex_mem_rd;
    logic          ex_mem_wr;
    logic [W-1:0]  ex_st_data;
    // pipeline control
    logic          mem_stall;
    logic          flush;
    // MEM side
    logic          mem_valid;
    logic [W-1:0]  mem_result;
    logic [RW-1:0] mem_wr_reg;
    logic          mem_wr_en;
    logic          mem_mem_rd;
    logic          mem_mem_wr;
    logic [W-1:0]  mem_st_data;
    logic          mem_br_taken;
    logic [W-1:0]  mem_next_pc;
    // trap handshake
    logic          err;
    logic [W-1:0]  err_pc;
    logic          err_ack;

    modport master (
        output ex_valid, ex_alu_out, ex_ofl, ex_z, ex_sign, ex_cond_op,
               ex_trap_ofl, ex_pc_plus2, ex_br_target, ex_wr_reg, ex_wr_en,
               ex_mem_rd, ex_mem_wr, ex_st_data, mem_stall, flush, err_ack,
        input  ex_ready, mem_valid, mem_result, mem_wr_reg, mem_wr_en,
               mem_mem_rd, mem_mem_wr, mem_st_data, mem_br_taken,
               mem_next_pc, err, err_pc
    );

    modport slave (
        input  ex_valid, ex_alu_out, ex_ofl, ex_z, ex_sign, ex_cond_op,
               ex_trap_ofl, ex_pc_plus2, ex_br_target, ex_wr_reg, ex_wr_en,
               ex_mem_rd, ex_mem_wr, ex_st_data, mem_stall, flush, err_ack,
        output ex_ready, mem_valid, mem_result, mem_wr_reg, mem_wr_en,
               mem_mem_rd, mem_mem_wr, mem_st_data, mem_br_taken,
               mem_next_pc, err, err_pc
    );
endinterface

// File: rtl/ex_mem_reg_cond_eval.sv
// ex_mem_reg_cond_eval
//   Combinational resolution of the condition op against the ALU flags.
//   cond_op     in  3  condition op (cond_op_e encoding)
//   alu_out     in  W  ALU result
//   z/sign/ofl  in  1  ALU zero, result sign, overflow (carry in unsigned mode)
//   result      out W  alu_out, or a 0/1 word for the set-condition ops
//   br_taken    out 1  branch condition met (branch ops only)
//   wr_suppress out 1  op is a branch: register writeback must be blocked
module ex_mem_reg_cond_eval
    import ex_mem_reg_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [2:0]   cond_op,
    input  logic [W-1:0] alu_out,
    input  logic         z,
    input  logic         sign,
    input  logic         ofl,
    output logic [W-1:0] result,
    output logic         br_taken,
    output logic         wr_suppress
);

    always_comb begin
        result      = alu_out;
        br_taken    = 1'b0;
        wr_suppress = is_branch_op(cond_op);
        case (cond_op_e'(cond_op))
            COND_EQZ: br_taken = z;
            COND_NEZ: br_taken = ~z;
            COND_LTZ: br_taken = sign;
            COND_GEZ: br_taken = ~sign;
            COND_SEQ: result   = {{(W-1){1'b0}}, z};
            // signed less-than: true sign is the result sign corrected by overflow
            COND_SLT: result   = {{(W-1){1'b0}}, sign ^ ofl};
            COND_SCO: result   = {{(W-1){1'b0}}, ofl};
            default:  ;
        endcase
    end

endmodule

// File: rtl/ex_mem_reg.sv
// ex_mem_reg
//   EX/MEM pipeline register downstream of the 16-bit ALU. Registers the ALU
//   result and control bits, resolves branch/set-condition outcomes, raises a
//   sticky overflow trap (err/err_pc, cleared by err_ack) and back-pressures EX
//   on memory stall or while a trap is pending.
//   clk  in  clock, rising edge
//   rst  in  synchronous active-high reset
//   bus  slave modport of ex_mem_reg_if (EX inputs, MEM outputs, trap handshake)
module ex_mem_reg
    import ex_mem_reg_pkg::*;
#(
    parameter int W  = 16,
    parameter int RW = 3
) (
    input logic         clk,
    input logic         rst,
    ex_mem_reg_if.slave bus
);

    state_e        state, state_next;

    logic [W-1:0]  ce_result;
    logic          ce_br_taken;
    logic          ce_wr_suppress;

    logic          accept;
    logic          trap_hit;
    logic          load_instr;
    logic          stage_ld;

    logic          valid_q;
    logic [W-1:0]  result_q;
    logic [RW-1:0] wr_reg_q;
    logic          wr_en_q;
    logic          mem_rd_q;
    logic          mem_wr_q;
    logic [W-1:0]  st_data_q;
    logic          br_taken_q;
    logic [W-1:0]  next_pc_q;
    logic [W-1:0]  err_pc_q;

    ex_mem_reg_cond_eval #(.W(W)) u_cond_eval (
        .cond_op     (bus.ex_cond_op),
        .alu_out     (bus.ex_alu_out),
        .z           (bus.ex_z),
        .sign        (bus.ex_sign),
        .ofl         (bus.ex_ofl),
        .result      (ce_result),
        .br_taken    (ce_br_taken),
        .wr_suppress (ce_wr_suppress)
    );

    assign bus.ex_ready = ~bus.mem_stall & (state == ST_RUN);
    assign accept       = bus.ex_valid & bus.ex_ready;
    assign trap_hit     = accept & bus.ex_trap_ofl & bus.ex_ofl & ~bus.flush;
    // Anything accepted that is flushed or trapping enters as a bubble.
    assign load_instr   = accept & ~bus.flush & ~(bus.ex_trap_ofl & bus.ex_ofl);
    // flush overrides stall so a squash is never lost behind a busy memory.
    assign stage_ld     = bus.flush | ~bus.mem_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_RUN:  if (trap_hit)    state_next = ST_TRAP;
            ST_TRAP: if (bus.err_ack) state_next = ST_RUN;
            default: state_next = ST_RUN;
        endcase
    end

    // Single load-enabled register bank stands in for the discrete dff cells;
    // a bubble clears the whole record so all enables read 0 when invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            result_q   <= '0;
            wr_reg_q   <= '0;
            wr_en_q    <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            st_data_q  <= '0;
            br_taken_q <= 1'b0;
            next_pc_q  <= '0;
        end else if (stage_ld) begin
            if (load_instr) begin
                valid_q    <= 1'b1;
                result_q   <= ce_result;
                wr_reg_q   <= bus.ex_wr_reg;
                wr_en_q    <= bus.ex_wr_en & ~ce_wr_suppress;
                mem_rd_q   <= bus.ex_mem_rd;
                mem_wr_q   <= bus.ex_mem_wr;
                st_data_q  <= bus.ex_st_data;
                br_taken_q <= ce_br_taken;
                next_pc_q  <= ce_br_taken ? bus.ex_br_target : bus.ex_pc_plus2;
            end else begin
                valid_q    <= 1'b0;
                result_q   <= '0;
                wr_reg_q   <= '0;
                wr_en_q    <= 1'b0;
                mem_rd_q   <= 1'b0;
                mem_wr_q   <= 1'b0;
                st_data_q  <= '0;
                br_taken_q <= 1'b0;
                next_pc_q  <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_pc_q <= '0;
        end else if (trap_hit) begin
            err_pc_q <= bus.ex_pc_plus2;
        end
    end

    assign bus.mem_valid    = valid_q;
    assign bus.mem_result   = result_q;
    assign bus.mem_wr_reg   = wr_reg_q;
    assign bus.mem_wr_en    = wr_en_q;
    assign bus.mem_mem_rd   = mem_rd_q;
    assign bus.mem_mem_wr   = mem_wr_q;
    assign bus.mem_st_data  = st_data_q;
    assign bus.mem_br_taken = br_taken_q;
    assign bus.mem_next_pc  = next_pc_q;
    assign bus.err          = (state == ST_TRAP);
    assign bus.err_pc       = err_pc_q;

endmodule
